// File: rtl/mdu_if.sv
// EX <-> multiply/divide sequencer bundle.
// master drives the operation, slave returns status and result.
interface mdu_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            kill;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, op_a, op_b, kill,
      input  stall, busy, done, result
   );

   modport slave (
      input  start, funct3, op_a, op_b, kill,
      output stall, busy, done, result
   );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX ALU.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module mdu_seq #(
   parameter int XLEN = 32
) (
   input  logic  clk,
   input  logic  rst_n,
   mdu_if.slave  bus
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      func_q, func_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            neg_q, neg_d;
   logic            rneg_q, rneg_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            sgn_a, sgn_b;
   logic            neg_a, neg_b;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            div0, ovf;
   logic [XLEN-1:0] spec_res;
   logic [XLEN:0]   msum;
   logic [XLEN:0]   dsh, ddiff;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0] quo_s, rem_s;
`ifdef MDU_FAST_MUL_EN
   logic signed [XLEN:0]     fa, fb;
   logic signed [2*XLEN+1:0] fprod;
`endif

   // Operand signedness per funct3
   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      unique case (bus.funct3)
         3'b001: begin sgn_a = 1'b1; sgn_b = 1'b1; end
         3'b010: sgn_a = 1'b1;
         3'b100: begin sgn_a = 1'b1; sgn_b = 1'b1; end
         3'b110: begin sgn_a = 1'b1; sgn_b = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      neg_a = sgn_a & bus.op_a[XLEN-1];
      neg_b = sgn_b & bus.op_b[XLEN-1];
      abs_a = neg_a ? -bus.op_a : bus.op_a;
      abs_b = neg_b ? -bus.op_b : bus.op_b;
      div0  = (bus.op_b == '0);
      ovf   = ~bus.funct3[0]
            & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
            & (bus.op_b == '1);
      spec_res = '0;
      if (div0)
         spec_res = bus.funct3[1] ? bus.op_a : '1;
      else if (!bus.funct3[1])
         spec_res = {1'b1, {(XLEN-1){1'b0}}};
   end

`ifdef MDU_FAST_MUL_EN
   always_comb begin
      fa    = $signed({neg_a, bus.op_a});
      fb    = $signed({neg_b, bus.op_b});
      fprod = fa * fb;
   end
`endif

   // Shared step datapath: shift-add and restoring subtract
   always_comb begin
      msum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
      dsh   = {hi_q, lo_q[XLEN-1]};
      ddiff = dsh - {1'b0, b_q};
      prod   = {hi_q, lo_q};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_q : lo_q;
      rem_s  = rneg_q ? -hi_q : hi_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      func_d   = func_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      result_d = result_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.kill) begin
               func_d = bus.funct3;
               a_d    = abs_a;
               b_d    = abs_b;
               cnt_d  = '0;
               neg_d  = neg_a ^ neg_b;
               rneg_d = neg_a;
               hi_d   = '0;
               if (bus.funct3[2]) begin
                  lo_d = abs_a;
                  if (div0 || ovf) begin
                     result_d = spec_res;
                     state_d  = DONE;
                  end else begin
                     state_d = DIV;
                  end
               end else begin
`ifdef MDU_FAST_MUL_EN
                  lo_d     = abs_b;
                  result_d = (bus.funct3 == 3'b000) ?
                             fprod[XLEN-1:0] :
                             fprod[2*XLEN-1:XLEN];
                  state_d  = DONE;
`else
                  lo_d    = abs_b;
                  state_d = MUL;
`endif
               end
            end
         end
         MUL: begin
            hi_d  = msum[XLEN:1];
            lo_d  = {msum[0], lo_q[XLEN-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1))
               state_d = FIX;
         end
         DIV: begin
            if (!ddiff[XLEN]) begin
               hi_d = ddiff[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               hi_d = dsh[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(XLEN-1))
               state_d = FIX;
         end
         FIX: begin
            unique case (func_q)
               3'b000:  result_d = prod_s[XLEN-1:0];
               3'b100,
               3'b101:  result_d = quo_s;
               3'b110,
               3'b111:  result_d = rem_s;
               default: result_d = prod_s[2*XLEN-1:XLEN];
            endcase
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A flush discards any pending or completing result
      if (bus.kill && state_q != IDLE) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         func_q   <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         func_q   <= func_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign bus.stall  = (bus.start && state_q == IDLE)
                     || state_q == MUL
                     || state_q == DIV
                     || state_q == FIX;
   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE) && !bus.kill;
   assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised and directed bench for mdu_seq.
// Expected results come from plain 64-bit arithmetic.
module tb_mdu_seq;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_res;

   mdu_if #(.XLEN(32)) bus ();

   mdu_seq #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      logic [63:0] p;
      logic ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ov) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (ov) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      if (f[2]) begin
         if (b == 0) return 1;
         if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
         return 34;
      end
`ifdef MDU_FAST_MUL_EN
      return 1;
`else
      return 34;
`endif
   endfunction

   // Every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: got done=1 expected done=0 at %0t", $time);
         end else begin
            chk("result", bus.result, exp_q.pop_front());
         end
      end
   end

   task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit,
                         input bit use_lit, input bit hold);
      logic [31:0] e;
      int lat;
      int el;
      e  = model(f, a, b);
      el = exp_lat(f, a, b);
      if (use_lit) chk("model_pin", e, lit);
      exp_q.push_back(e);
      bus.funct3 = f;
      bus.op_a   = a;
      bus.op_b   = b;
      bus.start  = 1'b1;
      #1;
      chk("stall_issue", 32'(bus.stall), 32'd1);
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 60) begin
         chk("stall_busy", 32'(bus.stall), 32'd1);
         if (hold) begin
            bus.op_a   = $urandom;
            bus.op_b   = $urandom;
            bus.funct3 = 3'($urandom_range(0, 7));
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      chk("latency", 32'(lat), 32'(el));
      chk("done", 32'(bus.done), 32'd1);
      chk("stall_done", 32'(bus.stall), 32'd0);
      if (use_lit) chk("result_lit", bus.result, lit);
      @(posedge clk); #1;
      chk("busy_after", 32'(bus.busy), 32'd0);
      last_res = e;
   endtask

   initial begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      int          r;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.kill   = 1'b0;
      bus.funct3 = 3'd0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      last_res   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 0);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1, 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 0);
      run_op(3'd5, 32'd100, 32'd7, 32'd14, 1, 0);
      run_op(3'd7, 32'd100, 32'd7, 32'd2, 1, 0);
      run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

      // Kill mid-divide
      bus.funct3 = 3'd4;
      bus.op_a   = 32'd1000;
      bus.op_b   = 32'd3;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.kill = 1'b1;
      #1;
      chk("kill_no_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      bus.kill = 1'b0;
      chk("kill_busy", 32'(bus.busy), 32'd0);
      chk("kill_stall", 32'(bus.stall), 32'd0);
      chk("kill_result", bus.result, last_res);
      run_op(3'd7, 32'd12345, 32'd100, 32'd45, 1, 0);

      // Kill in the completion cycle
      bus.funct3 = 3'd5;
      bus.op_a   = 32'd5;
      bus.op_b   = 32'd0;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.kill  = 1'b1;
      #1;
      chk("kill_done_cycle", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      bus.kill = 1'b0;
      chk("kill_done_busy", 32'(bus.busy), 32'd0);
      last_res = 32'hFFFF_FFFF;

      // Kill with start in IDLE
      bus.funct3 = 3'd0;
      bus.op_a   = 32'd3;
      bus.op_b   = 32'd4;
      bus.start  = 1'b1;
      bus.kill   = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      chk("kill_start_busy", 32'(bus.busy), 32'd0);

      // Async reset mid-multiply
      bus.funct3 = 3'd0;
      bus.op_a   = 32'd3;
      bus.op_b   = 32'd5;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_stall", 32'(bus.stall), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_result", bus.result, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_res = '0;

      // Start held through busy
      run_op(3'd0, 32'd123, 32'd456, 32'd56088, 1, 1);
      run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1, 1);

      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         r  = $urandom_range(0, 9);
         if (r == 0) rb = 32'd0;
         if (r == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         if (r == 2) rb = 32'($urandom_range(1, 20));
         run_op(rf, ra, rb, 32'd0, 0, ($urandom_range(0, 3) == 0));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide sequencer attached alongside the EX stage ALU.
- Accepts one M-extension operation from EX and sequences a shared shift/add-subtract datapath over multiple cycles.
- Holds the pipeline via stall until the result is ready, then presents the result for one cycle.
- Honours pipeline flush by aborting the operation in flight.

Parameters:
- XLEN, 32: operand/result width. Only 32 is supported; the iteration counter is sized clog2(XLEN)+1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  EX presents a valid M-extension instruction (opcode 0110011, funct7 0000001)
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  32  rs1 value, already forwarded
- op_b  input  32  rs2 value, already forwarded
- kill  input  1  flush from EX/branch resolution; abort current operation
- stall  output  1  hold IF/ID/EX while the operation is pending
- busy  output  1  state != IDLE
- done  output  1  result valid, single-cycle pulse
- result  output  32  registered result, valid when done=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stall=0, busy=0, done=0, result=0; counter, accumulators and sign flags cleared. Reset mid-operation discards the operation with no done.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE
  - start=1 latches funct3, |op_a|, |op_b| and the sign flags.
  - Signed operand: DIV/REM both; MULH both; MULHSU op_a only.
  - Next state: MUL for funct3[2]=0, DIV otherwise.
  - Special cases go directly to DONE:
    - divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
    - signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- MUL: shift-add, one multiplier bit per cycle, 64-bit product. Exactly 32 cycles, counter 0..31, then FIX.
- DIV: restoring division, one quotient bit per cycle. Exactly 32 cycles, then FIX.
- FIX (1 cycle)
  - Negate the product if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Select the low/high product word, quotient or remainder; register result; go to DONE.
- DONE (1 cycle): done=1, result held; next state IDLE. A start in DONE is ignored (EX has not yet advanced).
- Latency: start sampled at edge T → done=1 in cycle T+34 (1 + 32 iterations + FIX). Special cases → done=1 in cycle T+1.
- stall = (start & state==IDLE) | state∈{MUL,DIV,FIX}. stall is combinational so EX holds from the issue cycle; stall=0 in DONE.
- start while busy (not DONE) is ignored; operands are not re-latched.
- kill=1 in any non-IDLE state → IDLE at the next edge, done suppressed, result unchanged.
  - kill and start together in IDLE: start is ignored.
  - kill has priority over DONE→IDLE completion: no done pulse in the kill cycle.
- result is retained after DONE until the next completion.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MUL* uses a combinational 33x33 signed multiplier. IDLE→DONE directly, so done appears in cycle T+1 and stall is high only in the issue cycle. The MUL state is not used.
- Undefined: the iterative 32-cycle MUL path described above. The divide path is unchanged in both builds.

Test Plan:
- MUL 7 × −3 (op_a=7, op_b=0xFFFFFFFD) → done at T+34, result=0xFFFFFFEB; stall high T..T+33. With MDU_FAST_MUL_EN: done at T+1.
- MULH 0x80000000 × 0x80000000 → result=0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each done at T+34.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, done at T+1; DIV 0x80000000/−1 → 0x80000000 and REM → 0, done at T+1.
- Start DIV, assert kill at T+10 → busy=0 and stall=0 from T+11, no done pulse, result keeps its previous value; a new start at T+12 completes normally.
- rst_n low at T+5 mid-MUL → immediately state IDLE, all outputs 0. Start held high during busy → no re-latch, exactly one done pulse.
